// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// Holds the FSM state enum, default parameters and the queue entry.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam int unsigned DEF_MEM_BYTES = 256;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   // Misaligned or past the last full word of memory.
   function automatic logic pc_illegal(
      input logic [31:0] pc,
      input logic [31:0] mem_bytes
   );
      return (pc[1:0] != 2'b00) || (pc > (mem_bytes - 32'd4));
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO with push/pop/flush; entry 0 is always the head.
// Ports: clk, reset, push, push_data, pop, flush -> count, head.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t e0;
   fetch_entry_t e1;
   logic         do_pop;
   logic         do_push;

   // Flush beats everything; a push into a full queue needs a pop.
   assign do_pop  = pop && (count != 2'd0) && !flush;
   assign do_push = push && !flush && ((count != 2'd2) || do_pop);
   assign head    = e0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e0    <= '0;
         e1    <= '0;
         count <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) e0 <= push_data;
               else               e1 <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  e0 <= push_data;
               end else begin
                  e0 <= e1;
                  e1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/FAULT FSM feeding a 2-entry queue.
// Ports: clk, reset, enable, imem_pc/imem_instr, redirect_*, out_*, fault*.
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
   parameter int unsigned QDEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fault,
   output logic [31:0] fault_pc
);

   localparam logic [31:0] MB32  = 32'(MEM_BYTES);
   localparam logic [1:0]  QFULL = 2'(QDEPTH);

   fetch_state_t state;
   fetch_state_t state_nx;
   logic [31:0]  pc;
   logic [31:0]  pc_nx;
   logic [31:0]  fault_pc_nx;
   logic [1:0]   count;
   fetch_entry_t head;
   fetch_entry_t push_data;
   logic         pc_bad;
   logic         rd_bad;
   logic         pop;
   logic         push;

   assign imem_pc   = pc;
   assign out_valid = (count != 2'd0);
   assign out_instr = head.instr;
   assign out_pc    = head.pc;
   assign fault     = (state == FAULT);

   assign pop    = out_valid && out_ready;
   assign pc_bad = pc_illegal(pc, MB32);
   assign rd_bad = pc_illegal(redirect_pc, MB32);

   // An illegal PC never reaches the queue, so a wrap is caught here.
   assign push = (state == RUN) && enable && !redirect_valid
              && !pc_bad && ((count != QFULL) || pop);

   assign push_data = '{instr: imem_instr, pc: pc};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         fault_pc <= 32'd0;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         fault_pc <= fault_pc_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      fault_pc_nx = fault_pc;
      if (redirect_valid) begin
         pc_nx = redirect_pc;
         if (rd_bad) begin
            state_nx    = FAULT;
            fault_pc_nx = redirect_pc;
         end else if (state == FAULT) begin
            state_nx = RUN;
         end else begin
            state_nx = enable ? RUN : IDLE;
         end
      end else begin
         if (push) pc_nx = pc + 32'd4;
         case (state)
            IDLE: begin
               if (pc_bad) begin
                  state_nx    = FAULT;
                  fault_pc_nx = pc;
               end else if (enable) begin
                  state_nx = RUN;
               end
            end
            RUN: begin
               if (pc_bad) begin
                  state_nx    = FAULT;
                  fault_pc_nx = pc;
               end else if (!enable) begin
                  state_nx = IDLE;
               end
            end
            FAULT:   ;
            default: state_nx = IDLE;
         endcase
      end
   end

   fetch_queue u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (count),
      .head      (head)
   );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus
// randomized traffic against a queue-based behavioural model.
module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fault;
   logic [31:0] fault_pc;

   always #5 clk = ~clk;

   instr_fetch_ctrl #(
      .RESET_PC  (32'h0),
      .MEM_BYTES (256),
      .QDEPTH    (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fault          (fault),
      .fault_pc       (fault_pc)
   );

   logic [7:0] mem [0:255];

   always_comb begin
      imem_instr = 32'hDEAD_BEEF;
      if (imem_pc <= 32'd252)
         imem_instr = {mem[imem_pc[7:0] + 8'd3], mem[imem_pc[7:0] + 8'd2],
                       mem[imem_pc[7:0] + 8'd1], mem[imem_pc[7:0]]};
   end

   int errors = 0;
   int checks = 0;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_FLT  = 2;

   int          m_st;
   logic [31:0] m_pc;
   logic [31:0] m_fpc;
   logic [63:0] q[$];

   function automatic logic ok_pc(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a <= 32'd252);
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
   endfunction

   task automatic model_reset();
      q.delete();
      m_st  = M_IDLE;
      m_pc  = 32'd0;
      m_fpc = 32'd0;
   endtask

   // Advance the model with the inputs as they stand, then one clock edge.
   task automatic cycle();
      bit          pop;
      bit          push;
      logic [31:0] old_pc;
      old_pc = m_pc;
      pop    = (q.size() != 0) && out_ready;
      if (redirect_valid) begin
         q.delete();
         m_pc = redirect_pc;
         if (!ok_pc(redirect_pc)) begin
            m_st  = M_FLT;
            m_fpc = redirect_pc;
         end else if (m_st == M_FLT) begin
            m_st = M_RUN;
         end else begin
            m_st = enable ? M_RUN : M_IDLE;
         end
      end else begin
         push = (m_st == M_RUN) && enable && ok_pc(m_pc)
             && ((q.size() < 2) || pop);
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back({word_at(m_pc), m_pc});
            m_pc = m_pc + 32'd4;
         end
         if (m_st != M_FLT && !ok_pc(old_pc)) begin
            m_st  = M_FLT;
            m_fpc = old_pc;
         end else if (m_st == M_IDLE && enable) begin
            m_st = M_RUN;
         end else if (m_st == M_RUN && !enable) begin
            m_st = M_IDLE;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic hard_reset();
      reset          = 1'b1;
      enable         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      out_ready      = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (out_instr !== 32'd0 || out_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_out: got %h/%h expected 0/0", out_instr, out_pc);
      end
      checks++;
      if (fault !== 1'b0 || fault_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_fault: got %b/%h expected 0/0", fault, fault_pc);
      end
      checks++;
      if (imem_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_pc: got %h expected 0", imem_pc);
      end
      hard_reset();
   endtask

   task automatic test_latency();
      hard_reset();
      enable    = 1'b1;
      out_ready = 1'b1;
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL lat_edge1: got %b expected 0", out_valid);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h0001_1020 || out_pc !== 32'd0) begin
         errors++;
         $display("FAIL lat_word0: got v=%b %h@%h expected 1 00011020@0",
                  out_valid, out_instr, out_pc);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h0085_3022 || out_pc !== 32'd4) begin
         errors++;
         $display("FAIL lat_word1: got v=%b %h@%h expected 1 00853022@4",
                  out_valid, out_instr, out_pc);
      end
   endtask

   task automatic test_backpressure();
      hard_reset();
      enable    = 1'b1;
      out_ready = 1'b0;
      repeat (5) cycle();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0 || imem_pc !== 32'd8) begin
         errors++;
         $display("FAIL bp_stall: got v=%b head=%h pc=%h expected 1 0 8",
                  out_valid, out_pc, imem_pc);
      end
      out_ready = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         cycle();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)
             || out_instr !== word_at(32'(4 * i))) begin
            errors++;
            $display("FAIL bp_drain%0d: got v=%b %h@%h expected 1 %h@%h", i,
                     out_valid, out_instr, out_pc, word_at(32'(4 * i)), 4 * i);
         end
      end
   endtask

   task automatic test_redirect();
      hard_reset();
      enable    = 1'b1;
      out_ready = 1'b0;
      repeat (3) cycle();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'd16;
      cycle();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || imem_pc !== 32'd16) begin
         errors++;
         $display("FAIL rd_flush: got v=%b pc=%h expected 0 10", out_valid, imem_pc);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd16) begin
         errors++;
         $display("FAIL rd_first: got v=%b head=%h expected 1 10", out_valid, out_pc);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd20) begin
         errors++;
         $display("FAIL rd_second: got v=%b head=%h expected 1 14", out_valid, out_pc);
      end
   endtask

   task automatic test_fault_wrap();
      bit          saw;
      logic [31:0] got_instr;
      saw       = 1'b0;
      got_instr = 32'd0;
      hard_reset();
      enable         = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'd240;
      cycle();
      redirect_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (out_valid && out_pc == 32'd252) begin
            saw       = 1'b1;
            got_instr = out_instr;
         end
         if (fault) break;
      end
      checks++;
      if (!saw || got_instr !== word_at(32'd252)) begin
         errors++;
         $display("FAIL wrap_last: got seen=%b %h expected 1 %h",
                  saw, got_instr, word_at(32'd252));
      end
      checks++;
      if (fault !== 1'b1 || fault_pc !== 32'd256) begin
         errors++;
         $display("FAIL wrap_fault: got %b/%h expected 1/100", fault, fault_pc);
      end
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (out_valid !== 1'b0 || imem_pc !== 32'd256) begin
            errors++;
            $display("FAIL wrap_hold: got v=%b pc=%h expected 0 100",
                     out_valid, imem_pc);
         end
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'd0;
      cycle();
      redirect_valid = 1'b0;
      checks++;
      if (fault !== 1'b0 || imem_pc !== 32'd0) begin
         errors++;
         $display("FAIL wrap_recover: got f=%b pc=%h expected 0 0", fault, imem_pc);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0) begin
         errors++;
         $display("FAIL wrap_resume: got v=%b head=%h expected 1 0", out_valid, out_pc);
      end
   endtask

   task automatic test_illegal_redirect();
      hard_reset();
      enable    = 1'b1;
      out_ready = 1'b0;
      repeat (3) cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'd6;
      cycle();
      redirect_valid = 1'b0;
      checks++;
      if (fault !== 1'b1 || fault_pc !== 32'd6 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ill_rd: got f=%b fpc=%h v=%b expected 1 6 0",
                  fault, fault_pc, out_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'd0;
      cycle();
      redirect_valid = 1'b0;
      repeat (3) cycle();
      checks++;
      if (out_valid !== 1'b1 || imem_pc !== 32'd8) begin
         errors++;
         $display("FAIL ill_refill: got v=%b pc=%h expected 1 8", out_valid, imem_pc);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || fault !== 1'b0 || imem_pc !== 32'd0) begin
         errors++;
         $display("FAIL async_rst: got v=%b f=%b pc=%h expected 0 0 0",
                  out_valid, fault, imem_pc);
      end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_random();
      int r;
      hard_reset();
      for (int n = 0; n < 800; n++) begin
         enable         = ($urandom_range(0, 9) != 0);
         out_ready      = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         r = $urandom_range(0, 9);
         if (r <= 6)      redirect_pc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         else if (r == 7) redirect_pc = {24'd0, 6'($urandom_range(0, 63)), 2'b10};
         else if (r == 8) redirect_pc = 32'd256 + {$urandom_range(0, 15), 2'b00};
         else             redirect_pc = 32'hFFFF_FFFC;
         cycle();
         checks++;
         if (out_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL rnd_valid@%0d: got %b expected %b", n, out_valid, q.size() != 0);
         end
         if (q.size() != 0) begin
            checks++;
            if ({out_instr, out_pc} !== q[0]) begin
               errors++;
               $display("FAIL rnd_head@%0d: got %h@%h expected %h@%h", n,
                        out_instr, out_pc, q[0][63:32], q[0][31:0]);
            end
         end
         checks++;
         if (imem_pc !== m_pc) begin
            errors++;
            $display("FAIL rnd_pc@%0d: got %h expected %h", n, imem_pc, m_pc);
         end
         checks++;
         if (fault !== (m_st == M_FLT)) begin
            errors++;
            $display("FAIL rnd_fault@%0d: got %b expected %b", n, fault, m_st == M_FLT);
         end
         if (m_st == M_FLT) begin
            checks++;
            if (fault_pc !== m_fpc) begin
               errors++;
               $display("FAIL rnd_fpc@%0d: got %h expected %h", n, fault_pc, m_fpc);
            end
         end
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      enable         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      out_ready      = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h20; mem[1] = 8'h10; mem[2] = 8'h01; mem[3] = 8'h00;
      mem[4] = 8'h22; mem[5] = 8'h30; mem[6] = 8'h85; mem[7] = 8'h00;
      model_reset();
      test_reset();
      test_latency();
      test_backpressure();
      test_redirect();
      test_fault_wrap();
      test_illegal_redirect();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
